// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM register and the data memory: decodes
// the access, places store lanes, handshakes with the memory and extends load
// data. It stalls the pipeline while an access is in flight and gives up after
// TIMEOUT_CYCLES cycles without an acknowledge.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  MEM_READ,
   input  logic [3:0]  MEM_WRITE,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic [31:0] DATA_READED,
   output logic        BUSY_WAIT,
   output logic        ACCESS_FAULT,
   output logic        MEM_READ_REQ,
   output logic        MEM_WRITE_REQ,
   output logic [29:0] MEM_WORD_ADDR,
   output logic [31:0] MEM_WDATA,
   output logic [3:0]  MEM_BYTE_EN,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ACK
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             timeout_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;

   logic             rd_en;
   logic             wr_en;
   logic             rd_ok;
   logic             wr_ok;
   logic             any_en;
   logic             req_valid;
   logic [3:0]       be_c;
   logic [31:0]      wdata_c;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_c;
   logic             acc_ack_c;
   logic             acc_tmo_c;

   // Request decode: one enable, legal funct3, natural alignment
   always_comb begin
      rd_en = MEM_READ[3];
      wr_en = MEM_WRITE[3];
      rd_ok = 1'b0;
      wr_ok = 1'b0;
      case (MEM_READ[2:0])
         3'b000, 3'b100: rd_ok = 1'b1;
         3'b001, 3'b101: rd_ok = ~ADDRESS[0];
         3'b010:         rd_ok = (ADDRESS[1:0] == 2'b00);
         default:        rd_ok = 1'b0;
      endcase
      case (MEM_WRITE[2:0])
         3'b000:  wr_ok = 1'b1;
         3'b001:  wr_ok = ~ADDRESS[0];
         3'b010:  wr_ok = (ADDRESS[1:0] == 2'b00);
         default: wr_ok = 1'b0;
      endcase
      any_en    = rd_en | wr_en;
      req_valid = (rd_en ^ wr_en) & (rd_en ? rd_ok : wr_ok);
   end

   // Store lane placement: replicate the datum across the word, enable its lanes
   always_comb begin
      be_c    = 4'b0000;
      wdata_c = 32'h0;
      case (MEM_WRITE[2:0])
         3'b000: begin
            be_c    = 4'b0001 << ADDRESS[1:0];
            wdata_c = {4{WRITE_DATA[7:0]}};
         end
         3'b001: begin
            be_c    = ADDRESS[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{WRITE_DATA[15:0]}};
         end
         3'b010: begin
            be_c    = 4'b1111;
            wdata_c = WRITE_DATA;
         end
         default: begin
            be_c    = 4'b0000;
            wdata_c = 32'h0;
         end
      endcase
   end

   // Load lane selection and extension from the latched offset/funct3
   always_comb begin
      byte_sel = MEM_RDATA[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
      case (f3_q)
         3'b000:  load_c = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_c = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_c = {24'h0, byte_sel};
         3'b101:  load_c = {16'h0, half_sel};
         default: load_c = MEM_RDATA;
      endcase
   end

   // Completion conditions; an acknowledge wins over a simultaneous timeout
   always_comb begin
      acc_ack_c = (state == ACCESS) & MEM_ACK;
      acc_tmo_c = (state == ACCESS) & ~MEM_ACK & (cnt == CNT_LAST);
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = ACCESS;
         ACCESS:  if (acc_ack_c || acc_tmo_c) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: stall and fault flags, both silenced during reset
   always_comb begin
      BUSY_WAIT    = 1'b0;
      ACCESS_FAULT = 1'b0;
      if (!RESET) begin
         case (state)
            IDLE: begin
               BUSY_WAIT    = req_valid;
               ACCESS_FAULT = any_en & ~req_valid;
            end
            ACCESS:  BUSY_WAIT = 1'b1;
            DONE:    ACCESS_FAULT = timeout_q;
            default: BUSY_WAIT = 1'b0;
         endcase
      end
   end

   // Request registers, timeout counter and load result
   always_ff @(posedge CLK) begin
      if (RESET) begin
         DATA_READED   <= 32'h0;
         MEM_READ_REQ  <= 1'b0;
         MEM_WRITE_REQ <= 1'b0;
         MEM_WORD_ADDR <= 30'h0;
         MEM_WDATA     <= 32'h0;
         MEM_BYTE_EN   <= 4'b0000;
         cnt           <= '0;
         timeout_q     <= 1'b0;
         f3_q          <= 3'b000;
         off_q         <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               timeout_q <= 1'b0;
               if (req_valid) begin
                  MEM_READ_REQ  <= rd_en;
                  MEM_WRITE_REQ <= wr_en;
                  MEM_WORD_ADDR <= ADDRESS[31:2];
                  MEM_WDATA     <= wr_en ? wdata_c : 32'h0;
                  MEM_BYTE_EN   <= wr_en ? be_c : 4'b0000;
                  f3_q          <= MEM_READ[2:0];
                  off_q         <= ADDRESS[1:0];
                  cnt           <= '0;
               end
            end
            ACCESS: begin
               if (acc_ack_c) begin
                  MEM_READ_REQ  <= 1'b0;
                  MEM_WRITE_REQ <= 1'b0;
                  cnt           <= '0;
                  if (MEM_READ_REQ) DATA_READED <= load_c;
               end else if (acc_tmo_c) begin
                  MEM_READ_REQ  <= 1'b0;
                  MEM_WRITE_REQ <= 1'b0;
                  cnt           <= '0;
                  DATA_READED   <= 32'h0;
                  timeout_q     <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE:    timeout_q <= 1'b0;
            default: timeout_q <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized transactions compared against a behavioural model.
module tb_mem_access_unit;

   localparam int unsigned T = 4;

   logic        clk;
   logic        reset;
   logic [3:0]  mem_read;
   logic [3:0]  mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] data_readed;
   logic        busy_wait;
   logic        access_fault;
   logic        mem_read_req;
   logic        mem_write_req;
   logic [29:0] mem_word_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] model_data;

   mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
      .CLK          (clk),
      .RESET        (reset),
      .MEM_READ     (mem_read),
      .MEM_WRITE    (mem_write),
      .ADDRESS      (address),
      .WRITE_DATA   (write_data),
      .DATA_READED  (data_readed),
      .BUSY_WAIT    (busy_wait),
      .ACCESS_FAULT (access_fault),
      .MEM_READ_REQ (mem_read_req),
      .MEM_WRITE_REQ(mem_write_req),
      .MEM_WORD_ADDR(mem_word_addr),
      .MEM_WDATA    (mem_wdata),
      .MEM_BYTE_EN  (mem_byte_en),
      .MEM_RDATA    (mem_rdata),
      .MEM_ACK      (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_read   = 4'h0;
      mem_write  = 4'h0;
      mem_ack    = 1'b0;
      address    = 32'h0;
      write_data = 32'h0;
   endtask

   // Access size in bytes, 0 when funct3 is not legal
   function automatic int size_of(input logic is_load, input logic [2:0] f3);
      if (is_load) begin
         case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
         endcase
      end
      case (f3)
         3'd0:    return 1;
         3'd1:    return 2;
         3'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input int a, input logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      b = (rd >> (8 * a)) & 32'hFF;
      h = (rd >> (16 * (a / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'h1_0000  : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] be_model(input int n, input int a);
      return 4'(((1 << n) - 1) << a);
   endfunction

   function automatic logic [31:0] wdata_model(input int n, input logic [31:0] d);
      logic [31:0] unit;
      logic [31:0] r;
      if (n == 4) return d;
      unit = d & ((32'd1 << (8 * n)) - 32'd1);
      r = 32'h0;
      for (int i = 0; i < 4 / n; i++) r = r | (unit << (8 * n * i));
      return r;
   endfunction

   // One transaction from IDLE; lat = ACCESS cycle carrying the ack, > T means none
   task automatic run_txn(input logic [3:0] rd, input logic [3:0] wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int lat,
                          input string tag, output int busy_cycles);
      logic ld;
      logic st;
      logic valid;
      logic timed_out;
      int   n;
      int   a;
      busy_cycles = 0;
      ld = rd[3];
      st = wr[3];
      a  = int'(addr[1:0]);
      n  = 0;
      if (ld && !st)      n = size_of(1'b1, rd[2:0]);
      else if (st && !ld) n = size_of(1'b0, wr[2:0]);
      valid = (n != 0) && (a % n == 0);

      mem_read = rd; mem_write = wr; address = addr; write_data = wd;
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
      if (busy_wait === 1'b1) busy_cycles++;

      if (!ld && !st) begin
         chk1({tag, "_noen_busy"}, busy_wait, 1'b0);
         chk1({tag, "_noen_fault"}, access_fault, 1'b0);
         next_cycle();
         chk1({tag, "_noen_rreq"}, mem_read_req, 1'b0);
         chk1({tag, "_noen_wreq"}, mem_write_req, 1'b0);
         chk32({tag, "_noen_data"}, data_readed, model_data);
         idle_inputs();
         return;
      end

      if (!valid) begin
         chk1({tag, "_bad_busy"}, busy_wait, 1'b0);
         chk1({tag, "_bad_fault"}, access_fault, 1'b1);
         next_cycle();
         chk1({tag, "_bad_rreq"}, mem_read_req, 1'b0);
         chk1({tag, "_bad_wreq"}, mem_write_req, 1'b0);
         chk1({tag, "_bad_busy2"}, busy_wait, 1'b0);
         chk32({tag, "_bad_data"}, data_readed, model_data);
         idle_inputs();
         return;
      end

      chk1({tag, "_idle_busy"}, busy_wait, 1'b1);
      chk1({tag, "_idle_fault"}, access_fault, 1'b0);
      next_cycle();

      for (int k = 1; k <= int'(T); k++) begin
         address    = $urandom;
         write_data = $urandom;
         mem_ack    = (k == lat);
         mem_rdata  = (k == lat) ? rdata : $urandom;
         #1;
         if (busy_wait === 1'b1) busy_cycles++;
         chk1({tag, "_acc_busy"}, busy_wait, 1'b1);
         chk1({tag, "_acc_fault"}, access_fault, 1'b0);
         chk1({tag, "_acc_rreq"}, mem_read_req, ld);
         chk1({tag, "_acc_wreq"}, mem_write_req, st);
         chk32({tag, "_acc_waddr"}, 32'(mem_word_addr), 32'(addr >> 2));
         if (st) begin
            chk32({tag, "_acc_be"}, 32'(mem_byte_en), 32'(be_model(n, a)));
            chk32({tag, "_acc_wdata"}, mem_wdata, wdata_model(n, wd));
         end
         next_cycle();
         if (k == lat) break;
      end

      timed_out = (lat > int'(T));
      if (timed_out)  model_data = 32'h0;
      else if (ld)    model_data = load_model(rd[2:0], a, rdata);

      // DONE: request still presented and a stray ack, neither may take effect
      mem_read = rd; mem_write = wr; address = addr; write_data = wd;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      #1;
      if (busy_wait === 1'b1) busy_cycles++;
      chk1({tag, "_done_busy"}, busy_wait, 1'b0);
      chk1({tag, "_done_fault"}, access_fault, timed_out);
      chk1({tag, "_done_rreq"}, mem_read_req, 1'b0);
      chk1({tag, "_done_wreq"}, mem_write_req, 1'b0);
      chk32({tag, "_done_data"}, data_readed, model_data);
      next_cycle();

      idle_inputs();
      #1;
      chk1({tag, "_post_busy"}, busy_wait, 1'b0);
      chk1({tag, "_post_fault"}, access_fault, 1'b0);
      chk1({tag, "_post_rreq"}, mem_read_req, 1'b0);
      chk1({tag, "_post_wreq"}, mem_write_req, 1'b0);
      chk32({tag, "_post_data"}, data_readed, model_data);
   endtask

   initial begin
      int busy;
      int sel;
      int lat;
      logic [3:0] rd;
      logic [3:0] wr;

      // Reset with conflicting enables present: flags must stay low
      reset = 1'b1; mem_read = 4'b1010; mem_write = 4'b1000; address = 32'h0;
      write_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
      model_data = 32'h0;
      next_cycle();
      next_cycle();
      chk1("rst_busy", busy_wait, 1'b0);
      chk1("rst_fault", access_fault, 1'b0);
      chk32("rst_data", data_readed, 32'h0);
      chk1("rst_rreq", mem_read_req, 1'b0);
      chk1("rst_wreq", mem_write_req, 1'b0);
      chk32("rst_waddr", 32'(mem_word_addr), 32'h0);
      chk32("rst_wdata", mem_wdata, 32'h0);
      chk32("rst_be", 32'(mem_byte_en), 32'h0);
      reset = 1'b0;
      idle_inputs();
      #1;
      chk1("idle_busy", busy_wait, 1'b0);
      chk1("idle_fault", access_fault, 1'b0);
      next_cycle();

      // LB at 0x1003, ack on third ACCESS cycle
      run_txn(4'b1000, 4'b0000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3, "lb", busy);
      chk32("lb_busy_cycles", 32'(busy), 32'd4);
      chk32("lb_result", data_readed, 32'hFFFF_FF80);

      // LHU at 0x2002
      run_txn(4'b1101, 4'b0000, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1, "lhu", busy);
      chk32("lhu_result", data_readed, 32'h0000_BEEF);

      // SB at 0x0001 leaves the load result alone
      run_txn(4'b0000, 4'b1000, 32'h0000_0001, 32'h0000_00AB, 32'h5555_5555, 2, "sb", busy);
      chk32("sb_keep_data", data_readed, 32'h0000_BEEF);

      // Misaligned LW faults without a request
      run_txn(4'b1010, 4'b0000, 32'h0000_0006, 32'h0, 32'h0, 1, "lw_misal", busy);
      chk32("lw_misal_busy_cycles", 32'(busy), 32'd0);

      // Both enables at once is a fault
      run_txn(4'b1010, 4'b1010, 32'h0000_0008, 32'h0, 32'h0, 1, "both_en", busy);

      // Reset on the second ACCESS cycle of an SW, then a late ack
      mem_read = 4'h0; mem_write = 4'b1010; address = 32'h0000_0040; write_data = 32'h1234_5678;
      #1;
      chk1("swrst_idle_busy", busy_wait, 1'b1);
      next_cycle();
      #1;
      chk1("swrst_acc1_wreq", mem_write_req, 1'b1);
      next_cycle();
      reset = 1'b1;
      #1;
      chk1("swrst_forced_busy", busy_wait, 1'b0);
      chk1("swrst_forced_fault", access_fault, 1'b0);
      next_cycle();
      reset = 1'b0;
      idle_inputs();
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      model_data = 32'h0;
      chk1("swrst_wreq", mem_write_req, 1'b0);
      chk1("swrst_rreq", mem_read_req, 1'b0);
      chk32("swrst_data", data_readed, 32'h0);
      chk32("swrst_waddr", 32'(mem_word_addr), 32'h0);
      chk32("swrst_wdata", mem_wdata, 32'h0);
      chk32("swrst_be", 32'(mem_byte_en), 32'h0);
      chk1("swrst_busy", busy_wait, 1'b0);
      next_cycle();
      mem_ack = 1'b0;
      #1;
      chk1("swrst_late_busy", busy_wait, 1'b0);
      chk1("swrst_late_fault", access_fault, 1'b0);
      chk32("swrst_late_data", data_readed, 32'h0);
      next_cycle();

      // LW success then LW timeout
      run_txn(4'b1010, 4'b0000, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 2, "lw", busy);
      chk32("lw_result", data_readed, 32'hCAFE_F00D);
      run_txn(4'b1010, 4'b0000, 32'h0000_0100, 32'h0, 32'h1111_1111, int'(T) + 1, "lw_tmo", busy);
      chk32("lw_tmo_busy_cycles", 32'(busy), 32'd5);
      chk32("lw_tmo_result", data_readed, 32'h0);

      // Ack on the timeout cycle counts as success
      run_txn(4'b1010, 4'b0000, 32'h0000_0020, 32'h0, 32'h0BAD_CAFE, int'(T), "lw_late", busy);
      chk32("lw_late_result", data_readed, 32'h0BAD_CAFE);

      // Randomized transactions
      for (int i = 0; i < 120; i++) begin
         sel = $urandom_range(0, 9);
         rd  = 4'($urandom);
         wr  = 4'($urandom);
         if (sel <= 3)      begin rd[3] = 1'b1; wr[3] = 1'b0; end
         else if (sel <= 6) begin rd[3] = 1'b0; wr[3] = 1'b1; end
         else if (sel == 7) begin rd[3] = 1'b1; wr[3] = 1'b1; end
         else               begin rd[3] = 1'b0; wr[3] = 1'b0; end
         lat = wr[3] ? $urandom_range(1, T) : $urandom_range(1, T + 1);
         run_txn(rd, wr, $urandom, $urandom, $urandom, lat, "rnd", busy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles in ACCESS without MEM_ACK before the access is abandoned; the legal range SHALL be 1..255.
REQ-002 The port list SHALL be, in order:
- CLK  in  1  clock; all state SHALL update on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MEM_READ  in  4  bit3 = load enable; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- MEM_WRITE  in  4  bit3 = store enable; [2:0] = funct3 (000 SB, 001 SH, 010 SW).
- ADDRESS  in  32  byte address from the EX/MEM register.
- WRITE_DATA  in  32  store data, right-aligned.
- DATA_READED  out  32  registered, extended load result, consumed by the MEM/WB register.
- BUSY_WAIT  out  1  pipeline stall to all pipeline registers.
- ACCESS_FAULT  out  1  bad decode, misaligned access, or timeout.
- MEM_READ_REQ  out  1  registered read request to the data memory.
- MEM_WRITE_REQ  out  1  registered write request to the data memory.
- MEM_WORD_ADDR  out  30  ADDRESS[31:2], registered.
- MEM_WDATA  out  32  lane-replicated store data, registered.
- MEM_BYTE_EN  out  4  byte-lane enables, registered.
- MEM_RDATA  in  32  word read data; valid when MEM_ACK = 1.
- MEM_ACK  in  1  one-cycle completion pulse from the memory.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-004 A request is valid when exactly one enable bit is set, funct3 is legal for that enable, and the address is aligned (LH/LHU/SH: ADDRESS[0]=0; LW/SW: ADDRESS[1:0]=00).
REQ-005 IDLE with a valid request: BUSY_WAIT SHALL be 1 combinationally in the same cycle, and the next edge SHALL enter ACCESS and register MEM_*_REQ, address, data and byte enables.
REQ-006 IDLE with any enable set but the request invalid: ACCESS_FAULT SHALL be 1 combinationally, BUSY_WAIT SHALL be 0, and no memory request SHALL be issued.
- This includes both enables set at once.
REQ-007 IDLE with no enable set: BUSY_WAIT and ACCESS_FAULT SHALL be 0.
REQ-008 ACCESS: BUSY_WAIT SHALL be 1 and the request outputs SHALL be held stable; an internal 8-bit counter SHALL increment each cycle.
REQ-009 ACCESS with MEM_ACK = 1: the next edge SHALL enter DONE, drop MEM_*_REQ, and clear the counter.
- For a load, the same edge SHALL load DATA_READED with the extended result.
REQ-010 ACCESS with the counter equal to TIMEOUT_CYCLES-1 and no MEM_ACK: the next edge SHALL enter DONE, drop the requests, set DATA_READED to 0, and set a registered timeout flag.
REQ-011 DONE SHALL last exactly one cycle, with BUSY_WAIT = 0, so that the pipeline registers advance at the closing edge.
- ACCESS_FAULT SHALL equal the timeout flag during DONE.
- No new request SHALL be launched from DONE.
- The next state SHALL be IDLE, and the timeout flag SHALL clear.
REQ-012 Store lanes SHALL be set as follows, with a = ADDRESS[1:0]:
- SB: BYTE_EN = 0001<<a; WDATA = byte replicated x4.
- SH: BYTE_EN = 0011 if a[1]=0, else 1100; WDATA = halfword replicated x2.
- SW: BYTE_EN = 1111; WDATA = WRITE_DATA.
REQ-013 Loads SHALL select the byte lane by a (or the half lane by a[1]).
- LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-014 A store SHALL leave DATA_READED unchanged.
REQ-015 DATA_READED SHALL hold its value until the next completed load.
REQ-016 MEM_ACK SHALL be ignored outside ACCESS.
REQ-017 MEM_ACK arriving on the same edge as the timeout SHALL be treated as success.
REQ-018 The counter SHALL never wrap, since TIMEOUT_CYCLES <= 255.

Reset
REQ-019 With RESET = 1 at a rising edge, the state SHALL become IDLE and all registered outputs and the counter SHALL become 0.
- Registered outputs: DATA_READED, MEM_READ_REQ, MEM_WRITE_REQ, MEM_WORD_ADDR, MEM_WDATA, MEM_BYTE_EN.
- The timeout flag SHALL also clear.
REQ-020 While RESET = 1, BUSY_WAIT and ACCESS_FAULT SHALL be forced to 0 regardless of the inputs.
REQ-021 Reset asserted in ACCESS SHALL abandon the access, with MEM_*_REQ at 0 after that edge.
- A MEM_ACK arriving after the reset SHALL be ignored.

Verification
REQ-022 The bench SHALL cover LB at ADDRESS=0x1003 with MEM_RDATA=0x80FF_1234 and ACK on the 3rd ACCESS cycle.
- Required: BUSY_WAIT high for 4 cycles, then one DONE cycle with DATA_READED=0xFFFF_FF80.
REQ-023 The bench SHALL cover LHU at 0x2002 with RDATA=0xBEEF_0000.
- Required: DATA_READED=0x0000_BEEF and MEM_WORD_ADDR=0x800.
REQ-024 The bench SHALL cover SB at 0x0001 with WRITE_DATA=0x0000_00AB.
- Required: BYTE_EN=0010 and WDATA=0xABAB_ABAB.
- Required: DATA_READED unchanged after ACK.
REQ-025 The bench SHALL cover LW at 0x0006.
- Required: ACCESS_FAULT=1 and BUSY_WAIT=0 in the same cycle, with no MEM_READ_REQ.
REQ-026 The bench SHALL cover LW with TIMEOUT_CYCLES=4 and no ACK.
- Required: 4 ACCESS cycles, then DONE with ACCESS_FAULT=1 and DATA_READED=0, then IDLE.
REQ-027 The bench SHALL cover RESET on the 2nd ACCESS cycle of an SW, followed by an ACK.
- Required: REQ outputs 0 after the reset edge, state IDLE, and all registered outputs 0.
